// File: rtl/text_cursor_writer.sv
// Purpose: turns a stream of ASCII characters into text-buffer cell writes and tracks the cursor.
// Latency: printable accepted at T -> write strobe at T+1 -> back in IDLE 3 cycles after buffer busy starts.
// Backpressure: char_ready low while a write or clear sweep is in flight; buffer handshake times out after 4 idle cycles.
module text_cursor_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [6:0]  char_data,
    input  logic        char_lang,
    input  logic [11:0] char_color,
    output logic        char_ready,
    input  logic        clear_req,
    output logic        buf_write_enable,
    output logic [6:0]  buf_write_x,
    output logic [4:0]  buf_write_y,
    output logic [6:0]  buf_write_data,
    output logic [11:0] buf_write_color,
    output logic        buf_write_lang,
    input  logic        buf_busy,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        clear_active,
    output logic        write_error
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    localparam logic [6:0] X_MAX = 7'(COLS - 1);
    localparam logic [4:0] Y_MAX = 5'(ROWS - 1);
    localparam logic [6:0] SPACE = 7'h20;
    localparam logic [6:0] DEL   = 7'h7F;
    localparam logic [6:0] CR    = 7'h0D;
    localparam logic [6:0] LF    = 7'h0A;
    localparam logic [6:0] BS    = 7'h08;

    state_t     state;
    logic       clearing;   // sweep in progress; reuses the write handshake states
    logic       is_bs;      // pending write is a backspace erase: cursor lands on the target
    logic [1:0] tmo_cnt;    // consecutive WAIT_BUSY cycles without buf_busy
    logic       printable;

    assign printable  = (char_data >= SPACE) && (char_data != DEL);
    assign char_ready = (state == IDLE) && !clearing;

    // Main controller: character decode, buffer handshake, clear sweep and cursor update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            clearing         <= 1'b0;
            is_bs            <= 1'b0;
            tmo_cnt          <= 2'd0;
            cursor_x         <= 7'd0;
            cursor_y         <= 5'd0;
            buf_write_enable <= 1'b0;
            buf_write_x      <= 7'd0;
            buf_write_y      <= 5'd0;
            buf_write_data   <= 7'd0;
            buf_write_color  <= 12'd0;
            buf_write_lang   <= 1'b0;
            clear_active     <= 1'b0;
            write_error      <= 1'b0;
        end else begin
            buf_write_enable <= 1'b0;
            write_error      <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= 2'd0;
                    if (clear_req) begin
                        // Clear wins over a simultaneous character, which stays unaccepted.
                        clearing         <= 1'b1;
                        clear_active     <= 1'b1;
                        is_bs            <= 1'b0;
                        buf_write_x      <= 7'd0;
                        buf_write_y      <= 5'd0;
                        buf_write_data   <= SPACE;
                        buf_write_color  <= 12'd0;
                        buf_write_lang   <= 1'b0;
                        buf_write_enable <= 1'b1;
                        state            <= ISSUE;
                    end else if (char_valid) begin
                        if (printable) begin
                            is_bs            <= 1'b0;
                            buf_write_x      <= cursor_x;
                            buf_write_y      <= cursor_y;
                            buf_write_data   <= char_data;
                            buf_write_color  <= char_color;
                            buf_write_lang   <= char_lang;
                            buf_write_enable <= 1'b1;
                            state            <= ISSUE;
                        end else if (char_data == CR) begin
                            cursor_x <= 7'd0;
                        end else if (char_data == LF) begin
                            cursor_x <= 7'd0;
                            cursor_y <= (cursor_y == Y_MAX) ? 5'd0 : cursor_y + 5'd1;
                        end else if (char_data == BS && (cursor_x != 7'd0 || cursor_y != 5'd0)) begin
                            is_bs            <= 1'b1;
                            buf_write_data   <= SPACE;
                            buf_write_color  <= 12'd0;
                            buf_write_lang   <= 1'b0;
                            buf_write_enable <= 1'b1;
                            state            <= ISSUE;
                            if (cursor_x != 7'd0) begin
                                buf_write_x <= cursor_x - 7'd1;
                                buf_write_y <= cursor_y;
                            end else begin
                                buf_write_x <= X_MAX;
                                buf_write_y <= cursor_y - 5'd1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (buf_busy) begin
                        tmo_cnt <= 2'd0;
                        state   <= WAIT_DONE;
                    end else if (tmo_cnt == 2'd3) begin
                        // Buffer never acknowledged: drop the write, abandon any sweep.
                        tmo_cnt     <= 2'd0;
                        write_error <= 1'b1;
                        state       <= IDLE;
                        if (clearing) begin
                            clearing     <= 1'b0;
                            clear_active <= 1'b0;
                            cursor_x     <= 7'd0;
                            cursor_y     <= 5'd0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 2'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!buf_busy) begin
                        if (clearing) begin
                            if (buf_write_x == X_MAX && buf_write_y == Y_MAX) begin
                                clearing     <= 1'b0;
                                clear_active <= 1'b0;
                                cursor_x     <= 7'd0;
                                cursor_y     <= 5'd0;
                                state        <= IDLE;
                            end else begin
                                if (buf_write_x == X_MAX) begin
                                    buf_write_x <= 7'd0;
                                    buf_write_y <= buf_write_y + 5'd1;
                                end else begin
                                    buf_write_x <= buf_write_x + 7'd1;
                                end
                                buf_write_enable <= 1'b1;
                                state            <= ISSUE;
                            end
                        end else begin
                            state <= IDLE;
                            if (is_bs) begin
                                cursor_x <= buf_write_x;
                                cursor_y <= buf_write_y;
                            end else if (buf_write_x == X_MAX) begin
                                cursor_x <= 7'd0;
                                cursor_y <= (buf_write_y == Y_MAX) ? 5'd0 : buf_write_y + 5'd1;
                            end else begin
                                cursor_x <= buf_write_x + 7'd1;
                                cursor_y <= buf_write_y;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_cursor_writer.sv
// Bench for text_cursor_writer: random and corner-case characters against a linear-position cursor model.
// A buffer model answers each write strobe with a configurable busy length (0 = never answers).
// A screen image captured from the strobes is compared with the model screen at the end.
module tb_text_cursor_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int NCELL = COLS * ROWS;
    localparam logic [19:0] BLANK = 20'h00020;

    logic        clk;
    logic        reset;
    logic        char_valid;
    logic [6:0]  char_data;
    logic        char_lang;
    logic [11:0] char_color;
    logic        char_ready;
    logic        clear_req;
    logic        buf_write_enable;
    logic [6:0]  buf_write_x;
    logic [4:0]  buf_write_y;
    logic [6:0]  buf_write_data;
    logic [11:0] buf_write_color;
    logic        buf_write_lang;
    logic        buf_busy;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        clear_active;
    logic        write_error;

    typedef struct packed {
        logic [6:0]  x;
        logic [4:0]  y;
        logic [11:0] color;
        logic        lang;
        logic [6:0]  data;
    } wr_t;

    wr_t         wq[$];
    logic [19:0] scr_dut[NCELL];
    logic [19:0] scr_mod[NCELL];
    int          cyc = 0;
    int          en_count, err_count, en_cyc, err_cyc, busy_cnt;
    int          buf_len;
    int          n_cmp, n_bad;
    int          p;

    text_cursor_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .reset(reset),
        .char_valid(char_valid), .char_data(char_data), .char_lang(char_lang),
        .char_color(char_color), .char_ready(char_ready), .clear_req(clear_req),
        .buf_write_enable(buf_write_enable), .buf_write_x(buf_write_x),
        .buf_write_y(buf_write_y), .buf_write_data(buf_write_data),
        .buf_write_color(buf_write_color), .buf_write_lang(buf_write_lang),
        .buf_busy(buf_busy), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .clear_active(clear_active), .write_error(write_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model and write monitor: logs strobes, answers with buf_len busy cycles.
    initial begin
        buf_busy = 1'b0; busy_cnt = 0; en_count = 0; err_count = 0; en_cyc = 0; err_cyc = 0;
        for (int i = 0; i < NCELL; i++) scr_dut[i] = 20'd0;
        forever begin
            @(negedge clk);
            buf_busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            if (buf_write_enable) begin
                wq.push_back(wr_t'{x: buf_write_x, y: buf_write_y, color: buf_write_color,
                                   lang: buf_write_lang, data: buf_write_data});
                en_count++;
                en_cyc   = cyc;
                busy_cnt = buf_len;
                if (buf_len > 0 && int'(buf_write_y) * COLS + int'(buf_write_x) < NCELL)
                    scr_dut[int'(buf_write_y) * COLS + int'(buf_write_x)] =
                        {buf_write_color, buf_write_lang, buf_write_data};
            end
            if (write_error) begin
                err_count++;
                err_cyc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cur_lin();
        return int'(cursor_y) * COLS + int'(cursor_x);
    endfunction

    function automatic int rnd_len();
        return ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 3));
    endfunction

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        while (!char_ready && w < 20000) begin
            @(negedge clk);
            w++;
        end
        check(tag, 32'(char_ready), 32'd1);
    endtask

    // Offer one character, predict its effect from linear cursor position, check everything.
    task automatic send_char(input logic [6:0] code, input logic [11:0] col, input logic lng, input int len);
        int acc, e0, r0, tgt, pa, exp_lat;
        logic ew, ee;
        logic [19:0] ed;
        buf_len = len;
        wait_ready("ready_before");
        e0 = en_count; r0 = err_count;
        ew = 1'b0; ee = 1'b0; tgt = p; pa = p; ed = 20'd0;
        if (code >= 7'h20 && code != 7'h7F) begin
            ew = 1'b1; ed = {col, lng, code}; pa = (p + 1) % NCELL;
        end else if (code == 7'h0D) begin
            pa = p - p % COLS;
        end else if (code == 7'h0A) begin
            pa = ((p / COLS + 1) % ROWS) * COLS;
        end else if (code == 7'h08 && p > 0) begin
            ew = 1'b1; tgt = p - 1; ed = BLANK; pa = p - 1;
        end
        if (ew && len == 0) begin
            ee = 1'b1; pa = p;
        end
        exp_lat = !ew ? 1 : (len == 0 ? 6 : len + 3);
        char_valid = 1'b1; char_data = code; char_color = col; char_lang = lng;
        acc = cyc;
        @(negedge clk);
        char_valid = 1'b0;
        wait_ready("ready_after");
        check("latency", 32'(cyc - acc), 32'(exp_lat));
        check("enables", 32'(en_count - e0), 32'(ew));
        check("errors", 32'(err_count - r0), 32'(ee));
        if (ew && en_count > e0) begin
            check("wr_pos", 32'(int'(wq[e0].y) * COLS + int'(wq[e0].x)), 32'(tgt));
            check("wr_dat", 32'({wq[e0].color, wq[e0].lang, wq[e0].data}), 32'(ed));
        end
        if (ew && !ee) scr_mod[tgt] = ed;
        p = pa;
        check("cursor", 32'(cur_lin()), 32'(p));
    endtask

    initial begin
        int base, bad, snap, diffs, r;
        logic [6:0] code;
        n_cmp = 0; n_bad = 0; p = 0; buf_len = 2;
        reset = 1'b1; char_valid = 1'b0; char_data = 7'd0; char_lang = 1'b0;
        char_color = 12'd0; clear_req = 1'b0;
        for (int i = 0; i < NCELL; i++) scr_mod[i] = 20'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cursor", 32'(cur_lin()), 32'd0);
        check("rst_enable", 32'(buf_write_enable), 32'd0);
        check("rst_fields", 32'({buf_write_x, buf_write_y, buf_write_data, buf_write_lang}), 32'd0);
        check("rst_color", 32'(buf_write_color), 32'd0);
        check("rst_clear_active", 32'(clear_active), 32'd0);
        check("rst_write_error", 32'(write_error), 32'd0);
        check("rst_ready", 32'(char_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // 'A' red at (0,0) with a 2-cycle-busy buffer
        send_char(7'h41, 12'hF00, 1'b0, 2);
        check("A_cursor_x", 32'(cursor_x), 32'd1);

        // Clear and character in the same cycle: clear wins, full sweep
        buf_len = 1;
        wait_ready("clr_ready_before");
        base = en_count;
        clear_req = 1'b1; char_valid = 1'b1; char_data = 7'h51; char_color = 12'hABC; char_lang = 1'b1;
        @(negedge clk);
        clear_req = 1'b0; char_valid = 1'b0;
        check("clr_active_on", 32'(clear_active), 32'd1);
        check("clr_ready_low", 32'(char_ready), 32'd0);
        r = 0;
        while (clear_active && r < 20000) begin
            @(negedge clk);
            r++;
        end
        check("clr_done", 32'(clear_active), 32'd0);
        check("clr_count", 32'(en_count - base), 32'(NCELL));
        bad = 0;
        for (int i = 0; i < NCELL; i++) begin
            if (base + i >= wq.size()) bad++;
            else if (int'(wq[base + i].y) * COLS + int'(wq[base + i].x) != i ||
                     {wq[base + i].color, wq[base + i].lang, wq[base + i].data} != BLANK) bad++;
        end
        check("clr_cells", 32'(bad), 32'd0);
        check("clr_cursor", 32'(cur_lin()), 32'd0);
        check("clr_ready_back", 32'(char_ready), 32'd1);
        p = 0;
        for (int i = 0; i < NCELL; i++) scr_mod[i] = BLANK;

        // Reset in the middle of a sweep
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_clr_active", 32'(clear_active), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_enable", 32'(buf_write_enable), 32'd0);
        check("mid_rst_clear_active", 32'(clear_active), 32'd0);
        check("mid_rst_cursor", 32'(cur_lin()), 32'd0);
        check("mid_rst_ready", 32'(char_ready), 32'd1);
        snap = en_count;
        repeat (20) @(negedge clk);
        check("mid_rst_no_enables", 32'(en_count - snap), 32'd0);
        p = 0;

        // Bottom-right wrap: 29 LF, 79 printables, then 'Z' at (79,29)
        for (int i = 0; i < ROWS - 1; i++) send_char(7'h0A, 12'd0, 1'b0, 1);
        for (int i = 0; i < COLS - 1; i++)
            send_char(7'($urandom_range(32, 126)), 12'($urandom), 1'($urandom), int'($urandom_range(1, 3)));
        check("pre_Z_cursor", 32'(cur_lin()), 32'(NCELL - 1));
        send_char(7'h5A, 12'h0F0, 1'b1, 2);
        check("wrap_cursor", 32'(cur_lin()), 32'd0);

        // Backspace at (0,0) is a no-op; at (0,5) it erases (79,4)
        send_char(7'h08, 12'd0, 1'b0, 2);
        for (int i = 0; i < 5; i++) send_char(7'h0A, 12'd0, 1'b0, 2);
        send_char(7'h08, 12'd0, 1'b0, 2);
        check("bs_cursor", 32'({cursor_x, cursor_y}), 32'({7'd79, 5'd4}));

        // Move to (12,3), then CR and LF on consecutive cycles
        send_char(7'h0D, 12'd0, 1'b0, 2);
        for (int i = 0; i < ROWS - 1; i++) send_char(7'h0A, 12'd0, 1'b0, 2);
        for (int i = 0; i < 12; i++) send_char(7'h61 + 7'(i), 12'h123, 1'b0, 1);
        wait_ready("crlf_ready_before");
        snap = en_count;
        char_valid = 1'b1; char_data = 7'h0D; char_color = 12'd0; char_lang = 1'b0;
        @(negedge clk);
        p = p - p % COLS;
        check("crlf_cr_cursor", 32'(cur_lin()), 32'(p));
        check("crlf_cr_ready", 32'(char_ready), 32'd1);
        char_data = 7'h0A;
        @(negedge clk);
        char_valid = 1'b0;
        p = ((p / COLS + 1) % ROWS) * COLS;
        check("crlf_lf_cursor", 32'(cur_lin()), 32'(p));
        check("crlf_lf_ready", 32'(char_ready), 32'd1);
        check("crlf_enables", 32'(en_count - snap), 32'd0);

        // Buffer never answers: timeout pulse 4 cycles after entering WAIT_BUSY
        send_char(7'h42, 12'h00F, 1'b0, 0);
        check("tmo_err_delay", 32'(err_cyc - en_cyc), 32'd5);

        // Random traffic
        for (int i = 0; i < 250; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       code = 7'($urandom_range(32, 126));
            else if (r == 6) code = 7'h0D;
            else if (r == 7) code = 7'h0A;
            else if (r == 8) code = 7'h08;
            else             code = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'($urandom_range(0, 31));
            send_char(code, 12'($urandom), 1'($urandom), rnd_len());
        end

        diffs = 0;
        for (int i = 0; i < NCELL; i++) if (scr_dut[i] !== scr_mod[i]) diffs++;
        check("screen", 32'(diffs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/text_cursor_writer.md
TEXT_CURSOR_WRITER -- requirements
Module: text_cursor_writer

Interface
REQ-001 Parameters (name, default, meaning): COLS, 80, text columns; ROWS, 30, text rows.
REQ-002 Ports (name direction width meaning):
- clk in 1: single clock, all logic on rising edge.
- reset in 1: synchronous, active-high.
- char_valid in 1: input character offered.
- char_data in 7: ASCII code.
- char_lang in 1: language-select bit stored with the character.
- char_color in 12: RGB444 colour stored with the character.
- char_ready out 1: character accepted when char_valid && char_ready.
- clear_req in 1: request full-screen clear.
- buf_write_enable out 1: write strobe to text buffer.
- buf_write_x out 7, buf_write_y out 5: target cell.
- buf_write_data out 7, buf_write_color out 12, buf_write_lang out 1: cell contents.
- buf_busy in 1: buffer write in progress.
- cursor_x out 7, cursor_y out 5: current cursor cell.
- clear_active out 1: high while a clear sweep runs.
- write_error out 1: one-cycle pulse on handshake timeout.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE; clear sweep reuses ISSUE/WAIT_* with an internal clearing flag.
REQ-004 char_ready SHALL be 1 only in IDLE with clearing flag low; 0 in all other states.
REQ-005 In IDLE, clear_req SHALL take priority over a simultaneous char_valid; the character is not accepted that cycle.
REQ-006 Printable codes 0x20-0x7E: latch {char_color, char_lang, char_data} and cursor as target, go to ISSUE.
REQ-007 ISSUE: buf_write_enable=1 for exactly one cycle, then WAIT_BUSY.
REQ-008 WAIT_BUSY: on buf_busy=1 go to WAIT_DONE; if buf_busy stays 0 for 4 consecutive cycles, pulse write_error, go to IDLE without moving cursor (clear sweep: abort clear, cursor to 0,0).
REQ-009 WAIT_DONE: on buf_busy=0 go to IDLE and apply cursor update in that transition.
REQ-010 buf_write_x/y/data/color/lang SHALL stay stable from ISSUE until return to IDLE.
REQ-011 Printable advance: x+1; at x=COLS-1 -> x=0, y+1; at y=ROWS-1 with x=COLS-1 -> (0,0) wrap.
REQ-012 0x0D (CR): x=0, no write, stay IDLE, cursor visible next cycle.
REQ-013 0x0A (LF): x=0, y+1, wrap ROWS-1 -> 0, no write, stay IDLE.
REQ-014 0x08 (BS): x>0 -> target (x-1,y); x=0,y>0 -> target (COLS-1,y-1); write 0x20, colour 0, lang 0 at target; cursor becomes target on completion; at (0,0) no-op, no write.
REQ-015 All other codes (0x00-0x1F except above, 0x7F): consumed, ignored, no cursor change.
REQ-016 Clear: clear_active=1, sweep cells row-major (0,0)..(COLS-1,ROWS-1) writing {12'h000,0,0x20} with full handshake per cell; after last cell clear_active=0, cursor (0,0), IDLE.
REQ-017 With a 2-cycle-busy buffer, printable char accepted at T: enable at T+1, IDLE/char_ready at T+5, cursor updated at T+5.
REQ-018 Cursor coordinates SHALL never exceed COLS-1 / ROWS-1.

Reset
REQ-019 reset=1 SHALL, on the next edge, force IDLE, clearing flag 0, cursor (0,0), buf_write_enable 0, buf_write_x/y/data/color/lang 0, clear_active 0, write_error 0, timeout counter 0; char_ready=1 after.
REQ-020 Reset mid-write or mid-clear SHALL abort immediately; no further buf_write_enable until a new request.

Verification
REQ-021 'A' (0x41), color 12'hF00, lang 0 at (0,0), buffer model busy 2 cycles -> one enable with x=0,y=0,data=0x41,color=F00; cursor (1,0) and char_ready at T+5.
REQ-022 Cursor (79,29), send 'Z' -> write at (79,29), cursor (0,0).
REQ-023 Cursor (0,5), send 0x08 -> write 0x20 at (79,4), cursor (79,4); at (0,0) 0x08 -> no enable, cursor (0,0).
REQ-024 Cursor (12,3), send 0x0D then 0x0A on consecutive cycles -> no enables, cursor (0,3) then (0,4), char_ready held 1.
REQ-025 clear_req and char_valid same cycle -> 2400 enables covering all cells with 0x20, char not accepted, clear_active falls, cursor (0,0); reset asserted mid-sweep -> enable stops, cursor (0,0).
REQ-026 buf_busy tied 0, send 'B' -> enable once, write_error pulses 4 cycles after WAIT_BUSY entry, cursor unchanged, char_ready returns 1.
